decoder_3_to_8: RTL and testbench
=================================

# decoder_3_to_8

Registered 3-to-8 line decoder: converts a 3-bit binary code into a one-hot 8-bit word, one clock cycle after sampling. It sits in datapath address- and select-generation logic, driving chip/row selects from a binary index. The output polarity is selectable, and an enable input gates the decode.

## Interface

Parameters:
- `OUT_ACTIVE_LOW`, default 0. 0 = selected line is 1 and others are 0; 1 = selected line is 0 and others are 1.

Ports:
- One clock; reset is synchronous and active-high.
- `clk`  input  1  rising-edge clock for all state.
- `rst`  input  1  synchronous, active-high reset.
- `en`  input  1  decode enable, sampled each rising edge.
- `code_in`  input  3  binary code to decode, sampled each rising edge.
- `code_out`  output  8  registered one-hot (or one-cold) decode.
- `out_valid`  output  1  registered; high when `code_out` reflects a decoded code.

## Operation

- Logical (active-high) decode: bit k of the decoded word = 1 iff `code_in` == k, for k = 0..7. Exactly one bit is set.
- Idle word: all zeros logically.
- Physical output:
  - `OUT_ACTIVE_LOW` = 0: `code_out` = logical word.
  - `OUT_ACTIVE_LOW` = 1: `code_out` = bitwise inverse of the logical word.
- Edge with `rst` = 1: `code_out` <= idle word (8'h00, or 8'hFF when active-low), `out_valid` <= 0.
- Edge with `rst` = 0, `en` = 1: `code_out` <= decode(`code_in`), `out_valid` <= 1.
- Edge with `rst` = 0, `en` = 0: `code_out` <= idle word, `out_valid` <= 0.
- `rst` has priority over `en`.
- All 8 input codes are legal; there is no invalid-input state.
- No X is ever propagated from reset state.

## Timing

- Latency: exactly 1 cycle from the sampling edge to the `code_out`/`out_valid` update.
- Throughput: one new code per cycle; back-to-back codes produce back-to-back outputs.
- Reset mid-stream: the output is idle on the cycle after the `rst` edge. The first valid output comes one cycle after the first edge with `rst` = 0 and `en` = 1.
- Wrap-around: a `code_in` sequence 7 -> 0 produces 8'h80 -> 8'h01 on consecutive cycles (active-high); no special case.
- Inputs changing between edges have no effect; only the value at the rising edge matters.
- All outputs are driven directly from flops (glitch-free); there is no combinational input-to-output path.

## Structure

- Shared package `decoder_pkg`:
  - `DEC_IN_W` = 3, `DEC_OUT_W` = 8.
  - Typedefs `dec_code_t` (3-bit) and `dec_onehot_t` (8-bit).
  - Function/constant for the idle word per polarity.
- Sub-module `onehot_decode_core`: purely combinational binary-to-one-hot decode (`code_in` -> logical one-hot), instantiated once.
- The top level holds the polarity inversion, the `en`/`rst` muxing, and the output registers.

## Test plan

- Reset: hold `rst` = 1 for 3 edges with `en` = 1 and `code_in` = 5 -> `code_out` = 8'h00, `out_valid` = 0 throughout.
- Sweep: `rst` = 0, `en` = 1, `code_in` = 0..7 on successive edges -> `code_out` = 8'h01, 02, 04, 08, 10, 20, 40, 80, each one cycle after its code; `out_valid` = 1.
- Wrap: drive `code_in` 6, 7, 0, 1 -> outputs 8'h40, 8'h80, 8'h01, 8'h02 on consecutive cycles.
- Enable gating: `code_in` = 3 with `en` toggling 1, 0, 1 -> `code_out` = 8'h08, 8'h00, 8'h08; `out_valid` = 1, 0, 1.
- Reset mid-stream: during the sweep, assert `rst` for one edge at `code_in` = 4 -> idle output next cycle; decode resumes on the following cycle with the current code.
- Polarity: `OUT_ACTIVE_LOW` = 1, `code_in` = 2 -> `code_out` = 8'hFB; under reset -> 8'hFF.

Source files
------------

// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_pkg
// Description : Shared widths, types and idle-word helper for the 3-to-8 decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

  localparam int DEC_IN_W  = 3;
  localparam int DEC_OUT_W = 8;

  typedef logic [DEC_IN_W-1:0]  dec_code_t;
  typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

  // Physical value driven when nothing is selected
  function automatic dec_onehot_t idle_word(input bit active_low);
    return active_low ? {DEC_OUT_W{1'b1}} : {DEC_OUT_W{1'b0}};
  endfunction

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/onehot_decode_core.sv
`default_nettype none
// ============================================================================
// Module      : onehot_decode_core
// Description : Combinational binary-to-one-hot decode (logical, active-high).
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_decode_core
  import decoder_pkg::*;
(
  input  dec_code_t   code_in,
  output dec_onehot_t onehot
);

  for (genvar k = 0; k < DEC_OUT_W; k++) begin : g_line
    assign onehot[k] = (code_in == dec_code_t'(k));
  end

endmodule : onehot_decode_core
`default_nettype wire

// File: rtl/decoder_3_to_8.sv
`default_nettype none
// ============================================================================
// Module      : decoder_3_to_8
// Description : Registered 3-to-8 decoder with enable and selectable polarity.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_3_to_8
  import decoder_pkg::*;
#(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DEC_IN_W-1:0]  code_in,
  output logic [DEC_OUT_W-1:0] code_out,
  output logic                 out_valid
);

  localparam dec_onehot_t C_IDLE = idle_word(OUT_ACTIVE_LOW);

  dec_onehot_t w_onehot;
  dec_onehot_t w_phys;
  dec_onehot_t r_code;
  logic        r_valid;

  onehot_decode_core u_core (
    .code_in (code_in),
    .onehot  (w_onehot)
  );

  if (OUT_ACTIVE_LOW) begin : g_active_low
    assign w_phys = ~w_onehot;
  end else begin : g_active_high
    assign w_phys = w_onehot;
  end

  // Reset wins over enable; both outputs come straight from flops
  always_ff @(posedge clk) begin
    if (rst) begin
      r_code  <= C_IDLE;
      r_valid <= 1'b0;
    end else if (en) begin
      r_code  <= w_phys;
      r_valid <= 1'b1;
    end else begin
      r_code  <= C_IDLE;
      r_valid <= 1'b0;
    end
  end

  assign code_out  = r_code;
  assign out_valid = r_valid;

endmodule : decoder_3_to_8
`default_nettype wire

// File: tb/tb_decoder_3_to_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_3_to_8
// Description : Directed scoreboard bench for both output polarities.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_3_to_8;

  typedef struct {
    logic [7:0] code_hi;
    logic [7:0] code_lo;
    logic       valid;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] code_in;
  logic [7:0] code_out_hi;
  logic [7:0] code_out_lo;
  logic       out_valid_hi;
  logic       out_valid_lo;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decoder_3_to_8 #(.OUT_ACTIVE_LOW(1'b0)) dut_hi (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .code_in   (code_in),
    .code_out  (code_out_hi),
    .out_valid (out_valid_hi)
  );

  decoder_3_to_8 #(.OUT_ACTIVE_LOW(1'b1)) dut_lo (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .code_in   (code_in),
    .code_out  (code_out_lo),
    .out_valid (out_valid_lo)
  );

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, want);
    end
  endtask

  // Drive one edge's worth of inputs, push the expectation, then compare after the edge.
  // With glitch set, code_in is disturbed between edges and restored before sampling.
  task automatic step(input string tag, input logic r, input logic e, input logic [2:0] c,
                      input bit glitch = 1'b0);
    exp_t       x;
    exp_t       got;
    logic [7:0] logical;
    rst     = r;
    en      = e;
    code_in = c;
    logical = (!r && e) ? (8'h01 << c) : 8'h00;
    x.code_hi = logical;
    x.code_lo = ~logical;
    x.valid   = !r && e;
    x.tag     = tag;
    exp_q.push_back(x);
    if (glitch) begin
      #2 code_in = ~c;
      #2 code_in = c;
    end
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check8({got.tag, "/code_hi"},  code_out_hi,  got.code_hi);
    check1({got.tag, "/valid_hi"}, out_valid_hi, got.valid);
    check8({got.tag, "/code_lo"},  code_out_lo,  got.code_lo);
    check1({got.tag, "/valid_lo"}, out_valid_lo, got.valid);
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b1;
    code_in = 3'd5;

    for (int i = 0; i < 3; i++) step("reset", 1'b1, 1'b1, 3'd5);

    // Anchor a few literal values independently of the model
    step("lit2", 1'b0, 1'b1, 3'd2);
    check8("lit_hi_02", code_out_hi, 8'h04);
    check8("lit_lo_FB", code_out_lo, 8'hFB);

    for (int i = 0; i < 8; i++) step("sweep", 1'b0, 1'b1, 3'(i));
    check8("lit_hi_80", code_out_hi, 8'h80);

    step("wrap6", 1'b0, 1'b1, 3'd6);
    step("wrap7", 1'b0, 1'b1, 3'd7);
    step("wrap0", 1'b0, 1'b1, 3'd0);
    check8("lit_wrap_01", code_out_hi, 8'h01);
    step("wrap1", 1'b0, 1'b1, 3'd1);

    step("en_on",  1'b0, 1'b1, 3'd3);
    step("en_off", 1'b0, 1'b0, 3'd3);
    check8("lit_en_off_lo", code_out_lo, 8'hFF);
    step("en_on2", 1'b0, 1'b1, 3'd3);

    for (int i = 0; i < 4; i++) step("mid_sweep", 1'b0, 1'b1, 3'(i));
    step("mid_rst", 1'b1, 1'b1, 3'd4);
    step("resume4", 1'b0, 1'b1, 3'd4);
    for (int i = 5; i < 8; i++) step("resume", 1'b0, 1'b1, 3'(i));

    step("rst_en0", 1'b1, 1'b0, 3'd6);
    step("glitch5", 1'b0, 1'b1, 3'd5, 1'b1);
    step("glitch0", 1'b0, 1'b1, 3'd0, 1'b1);
    step("tail_rst", 1'b1, 1'b0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_decoder_3_to_8
`default_nettype wire
